// File: rtl/psram_responder.sv
// psram_responder: device end of an asynchronous-mode multiplexed A/DQ
// CRAM/PSRAM bus. All pins are sampled on clk. Reads and writes are served
// from an internal synchronous RAM of 2**MEM_ADDR_BITS words. Higher address
// bits alias onto the RAM.
// Optional build macro: PSRAM_RESPONDER_PROTOCOL_CHECK_EN enables the sticky
// protocol_error checker. Without it, protocol_error is tied low.
module psram_responder #(
    parameter int ADDRESS_BITS  = 22,
    parameter int DATA_BITS     = 16,
    parameter int MEM_ADDR_BITS = 10,
    parameter int READ_LATENCY  = 2
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              ce_n,
    input  logic                              adv_n,
    input  logic                              we_n,
    input  logic                              oe_n,
    input  logic                              lb_n,
    input  logic                              ub_n,
    input  logic [ADDRESS_BITS-DATA_BITS-1:0] a,
    input  logic [DATA_BITS-1:0]              dq_in,
    output logic [DATA_BITS-1:0]              dq_out,
    output logic                              dq_oe,
    output logic                              protocol_error
);

    localparam int LANE_BITS = DATA_BITS / 2;
    localparam int CNT_W     = $clog2(READ_LATENCY);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(READ_LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE,
        ADDR,
        READ,
        WRITE
    } state_t;

    state_t state, state_nxt;

    logic [ADDRESS_BITS-1:0]  addr;
    logic [DATA_BITS-1:0]     wr_data;
    logic [1:0]               wr_be_n;
    logic [CNT_W-1:0]         counter;
    logic [DATA_BITS-1:0]     rd_data;
    logic [MEM_ADDR_BITS-1:0] mem_idx;

    logic load_addr;
    logic cap_wr;
    logic commit;
    logic start_rd;

    logic [DATA_BITS-1:0] mem [2**MEM_ADDR_BITS];

    // Address bits above the RAM index are latched but only alias; fold them
    // into a sink so the full latched address stays observable.
    logic unused_addr_bits;
    assign unused_addr_bits = ^addr;

    assign mem_idx = addr[MEM_ADDR_BITS-1:0];

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode and per-cycle datapath strobes.
    always_comb begin
        state_nxt = state;
        load_addr = 1'b0;
        cap_wr    = 1'b0;
        commit    = 1'b0;
        start_rd  = 1'b0;
        case (state)
            IDLE: begin
                if (!ce_n && !adv_n) begin
                    load_addr = 1'b1;
                    state_nxt = ADDR;
                end
            end
            ADDR: begin
                if (ce_n) begin
                    state_nxt = IDLE;
                end else if (!adv_n) begin
                    load_addr = 1'b1;
                end else if (!we_n) begin
                    cap_wr    = 1'b1;
                    state_nxt = WRITE;
                end else if (!oe_n) begin
                    start_rd  = 1'b1;
                    state_nxt = READ;
                end
            end
            READ: begin
                if (ce_n) begin
                    state_nxt = IDLE;
                end
            end
            WRITE: begin
                if (ce_n) begin
                    commit    = 1'b1;
                    state_nxt = IDLE;
                end else if (!we_n) begin
                    cap_wr = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Address latch, write buffer, read latency counter and DQ drive.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr    <= '0;
            wr_data <= '0;
            wr_be_n <= '1;
            counter <= '0;
            dq_out  <= '0;
            dq_oe   <= 1'b0;
        end else begin
            if (load_addr) begin
                addr <= {a, dq_in};
            end
            if (cap_wr) begin
                wr_data <= dq_in;
                wr_be_n <= {ub_n, lb_n};
            end
            if (start_rd) begin
                counter <= '0;
            end else if (state == READ && !oe_n && counter != CNT_MAX) begin
                counter <= counter + CNT_W'(1);
            end
            if (state == READ) begin
                if (ce_n || oe_n || !we_n) begin
                    dq_oe <= 1'b0;
                end else if (counter == CNT_MAX) begin
                    dq_oe  <= 1'b1;
                    dq_out <= rd_data;
                end
            end else begin
                dq_oe <= 1'b0;
            end
        end
    end

    // Backing store: byte-lane commit on CE# rise out of WRITE, read on entry to READ.
    always_ff @(posedge clk) begin
        if (commit) begin
            if (!wr_be_n[0]) begin
                mem[mem_idx][LANE_BITS-1:0] <= wr_data[LANE_BITS-1:0];
            end
            if (!wr_be_n[1]) begin
                mem[mem_idx][DATA_BITS-1:LANE_BITS] <= wr_data[DATA_BITS-1:LANE_BITS];
            end
        end
        if (start_rd) begin
            rd_data <= mem[mem_idx];
        end
    end

`ifdef PSRAM_RESPONDER_PROTOCOL_CHECK_EN
    logic proto_err_q;
    logic proto_viol;

    assign proto_viol = (!oe_n && !we_n)
                     || (!adv_n && ce_n)
                     || (state == ADDR && ce_n)
                     || ((state == READ || state == WRITE) && !adv_n);

    // Sticky violation flag, cleared only by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            proto_err_q <= 1'b0;
        end else if (proto_viol) begin
            proto_err_q <= 1'b1;
        end
    end

    assign protocol_error = proto_err_q;
`else
    assign protocol_error = 1'b0;
`endif

endmodule

// File: tb/tb_psram_responder.sv
// tb_psram_responder: scoreboard bench for psram_responder. Inputs change just
// after the falling edge; outputs are sampled on the falling edge.
module tb_psram_responder;

    localparam int ADDRESS_BITS  = 22;
    localparam int DATA_BITS     = 16;
    localparam int MEM_ADDR_BITS = 10;
    localparam int READ_LATENCY  = 2;
    localparam int AW            = ADDRESS_BITS - DATA_BITS;

`ifdef PSRAM_RESPONDER_PROTOCOL_CHECK_EN
    localparam logic PERR_ABORT = 1'b1;
`else
    localparam logic PERR_ABORT = 1'b0;
`endif

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 ce_n, adv_n, we_n, oe_n, lb_n, ub_n;
    logic [AW-1:0]        a;
    logic [DATA_BITS-1:0] dq_in;
    logic [DATA_BITS-1:0] dq_out;
    logic                 dq_oe;
    logic                 protocol_error;

    int n_checks = 0;
    int n_pass   = 0;

    logic [DATA_BITS-1:0] model_mem [2**MEM_ADDR_BITS];
    logic [DATA_BITS-1:0] exp_q [$];

    psram_responder #(
        .ADDRESS_BITS (ADDRESS_BITS),
        .DATA_BITS    (DATA_BITS),
        .MEM_ADDR_BITS(MEM_ADDR_BITS),
        .READ_LATENCY (READ_LATENCY)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .ce_n          (ce_n),
        .adv_n         (adv_n),
        .we_n          (we_n),
        .oe_n          (oe_n),
        .lb_n          (lb_n),
        .ub_n          (ub_n),
        .a             (a),
        .dq_in         (dq_in),
        .dq_out        (dq_out),
        .dq_oe         (dq_oe),
        .protocol_error(protocol_error)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic bus_idle();
        ce_n  = 1'b1;
        adv_n = 1'b1;
        we_n  = 1'b1;
        oe_n  = 1'b1;
        lb_n  = 1'b1;
        ub_n  = 1'b1;
        a     = '0;
        dq_in = '0;
    endtask

    task automatic write_word(input logic [ADDRESS_BITS-1:0] ad, input logic [DATA_BITS-1:0] d,
                              input logic lbn, input logic ubn);
        int idx;
        idx = int'(ad[MEM_ADDR_BITS-1:0]);
        ce_n  = 1'b0;
        adv_n = 1'b0;
        a     = ad[ADDRESS_BITS-1:DATA_BITS];
        dq_in = ad[DATA_BITS-1:0];
        @(negedge clk);
        adv_n = 1'b1;
        we_n  = 1'b0;
        lb_n  = lbn;
        ub_n  = ubn;
        dq_in = d;
        @(negedge clk);
        check("wr_no_drive_a", {31'd0, dq_oe}, 32'd0);
        @(negedge clk);
        check("wr_no_drive_b", {31'd0, dq_oe}, 32'd0);
        bus_idle();
        @(negedge clk);
        if (!lbn) model_mem[idx][7:0]  = d[7:0];
        if (!ubn) model_mem[idx][15:8] = d[15:8];
    endtask

    task automatic read_word(input logic [ADDRESS_BITS-1:0] ad);
        int lat;
        logic [DATA_BITS-1:0] exp;
        exp_q.push_back(model_mem[int'(ad[MEM_ADDR_BITS-1:0])]);
        ce_n  = 1'b0;
        adv_n = 1'b0;
        a     = ad[ADDRESS_BITS-1:DATA_BITS];
        dq_in = ad[DATA_BITS-1:0];
        @(negedge clk);
        adv_n = 1'b1;
        oe_n  = 1'b0;
        dq_in = '0;
        @(negedge clk);
        check("rd_oe_at_T", {31'd0, dq_oe}, 32'd0);
        lat = 0;
        while (!dq_oe && lat < 16) begin
            @(negedge clk);
            lat++;
        end
        check("rd_latency", lat, READ_LATENCY);
        exp = exp_q.pop_front();
        check("rd_data", {16'd0, dq_out}, {16'd0, exp});
        @(negedge clk);
        check("rd_hold_oe", {31'd0, dq_oe}, 32'd1);
        check("rd_hold_data", {16'd0, dq_out}, {16'd0, exp});
        bus_idle();
        @(negedge clk);
        check("rd_release", {31'd0, dq_oe}, 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus_idle();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_dq_oe", {31'd0, dq_oe}, 32'd0);
        check("rst_dq_out", {16'd0, dq_out}, 32'd0);
        check("rst_perr", {31'd0, protocol_error}, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Full-word write and readback.
        write_word(22'h000123, 16'hBEEF, 1'b0, 1'b0);
        read_word(22'h000123);

        // Upper-lane-only overwrite.
        write_word(22'h000005, 16'h1234, 1'b0, 1'b0);
        write_word(22'h000005, 16'hAB00, 1'b1, 1'b0);
        read_word(22'h000005);

        // Lower-lane-only overwrite on another word.
        write_word(22'h000006, 16'h0F0F, 1'b0, 1'b0);
        write_word(22'h000006, 16'hFFA5, 1'b0, 1'b1);
        read_word(22'h000006);

        // Aliasing beyond the backing store depth.
        write_word(22'h000400, 16'h5555, 1'b0, 1'b0);
        read_word(22'h000000);
        write_word(22'h3F03FF, 16'h9876, 1'b0, 1'b0);
        read_word(22'h0003FF);

        // Back-to-back write then read with one CE#-high cycle between.
        write_word(22'h000009, 16'hCAFE, 1'b0, 1'b0);
        read_word(22'h000009);
        check("perr_clean", {31'd0, protocol_error}, 32'd0);

        // Reset during a write data phase: nothing committed.
        write_word(22'h000077, 16'h1111, 1'b0, 1'b0);
        ce_n  = 1'b0;
        adv_n = 1'b0;
        a     = '0;
        dq_in = 16'h0077;
        @(negedge clk);
        adv_n = 1'b1;
        we_n  = 1'b0;
        lb_n  = 1'b0;
        ub_n  = 1'b0;
        dq_in = 16'h7777;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("midrst_dq_oe", {31'd0, dq_oe}, 32'd0);
        check("midrst_dq_out", {16'd0, dq_out}, 32'd0);
        check("midrst_perr", {31'd0, protocol_error}, 32'd0);
        @(negedge clk);
        bus_idle();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        read_word(22'h000077);

        // Address phase with no data phase.
        ce_n  = 1'b0;
        adv_n = 1'b0;
        a     = '0;
        dq_in = 16'h0005;
        @(negedge clk);
        ce_n  = 1'b1;
        adv_n = 1'b1;
        dq_in = '0;
        @(negedge clk);
        check("abort_perr", {31'd0, protocol_error}, {31'd0, PERR_ABORT});
        read_word(22'h000005);
        check("abort_perr_sticky", {31'd0, protocol_error}, {31'd0, PERR_ABORT});

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/psram_responder.md
# psram_responder

Synthesizable responder for the asynchronous-mode multiplexed-address/data CRAM/PSRAM bus; the device end of that bus. It samples CE#, ADV#, WE#, OE#, LB#/UB#, A and DQ on the system clock and serves reads and writes from an internal synchronous RAM. It sits in simulation benches and FPGA loopback builds in place of a physical PSRAM bank, so the PSRAM controller can be exercised without the real chip.

## Interface
Parameters:
- ADDRESS_BITS, 22, per-bank word address width: A carries bits [ADDRESS_BITS-1:DATA_BITS], DQ carries the low DATA_BITS during ADV#.
- DATA_BITS, 16, data width; must be 16 (two byte lanes).
- MEM_ADDR_BITS, 10, backing store depth is 2**MEM_ADDR_BITS words; must be <= ADDRESS_BITS.
- READ_LATENCY, 2, clocks from first sampled OE# low to valid DQ drive; minimum 2.

Ports:
- clk  in  1  system clock; all bus pins sampled on rising edge.
- reset  in  1  asynchronous, active-high reset.
- ce_n  in  1  chip enable, active low.
- adv_n  in  1  address valid, active low.
- we_n  in  1  write enable, active low.
- oe_n  in  1  output enable, active low.
- lb_n  in  1  lower byte enable (DQ[7:0]), active low.
- ub_n  in  1  upper byte enable (DQ[15:8]), active low.
- a  in  ADDRESS_BITS-DATA_BITS  upper address bits.
- dq_in  in  DATA_BITS  DQ as driven by the controller.
- dq_out  out  DATA_BITS  DQ drive value.
- dq_oe  out  1  DQ drive enable (tristate control at the top level).
- protocol_error  out  1  sticky protocol violation flag.

## Operation
- States: IDLE, ADDR, READ, WRITE.
- IDLE: on sampled ce_n=0 and adv_n=0, latch addr = {a, dq_in}; go ADDR. ce_n=0 without adv_n=0 is ignored.
- ADDR: ce_n=1 -> IDLE (abort, no access). adv_n=0 -> relatch address, stay. adv_n=1 and we_n=0 -> WRITE, capture dq_in, lb_n, ub_n into wr_buf. adv_n=1, we_n=1, oe_n=0 -> READ, counter=0, issue RAM read of addr. Otherwise stay.
- READ: counter increments each cycle oe_n=0 (saturating). When counter reaches READ_LATENCY-1, dq_out <= RAM data, dq_oe <= 1, held until exit. ce_n=1 or oe_n=1 sampled -> dq_oe <= 0; ce_n=1 -> IDLE.
- WRITE: each cycle with ce_n=0, we_n=0, recapture wr_buf (data and byte enables). On sampled ce_n=1: commit wr_buf to RAM at addr, only the lanes whose enable was low in wr_buf; go IDLE. we_n=1 while ce_n=0 holds wr_buf, no commit until ce_n rises.
- Memory index = addr[MEM_ADDR_BITS-1:0]; higher bits ignored (aliasing wrap-around).
- A committed write is visible to any read whose ADV# is sampled on or after the commit edge.
- Reset mid-access: state IDLE, no commit of pending wr_buf; RAM contents not reset.

## Timing
- Reset values: dq_oe=0, dq_out=0, protocol_error=0, state IDLE, counter=0.
- Read: OE# first sampled low at edge T -> dq_oe=1 and valid dq_out from edge T+READ_LATENCY; dq_oe falls at the edge after CE# or OE# sampled high.
- Write commit occurs on the edge that samples CE# high; data is the value sampled on the preceding edge.
- CE# high for one sample suffices between accesses; a new ADV# is accepted on the first edge after returning to IDLE.
- dq_oe never asserts while we_n sampled low.

## Configuration
- PSRAM_RESPONDER_PROTOCOL_CHECK_EN defined: protocol_error sets (sticky until reset) on any of: oe_n=0 and we_n=0 in the same sample; adv_n=0 with ce_n=1; CE# rising while in ADDR (access with no data phase); adv_n=0 sampled in READ or WRITE.
- Not defined: checker logic absent, protocol_error tied 0; functional behaviour identical.

## Test plan
- Write 0xBEEF to addr 0x000123 (both lanes), then read 0x000123 -> dq_out=0xBEEF, dq_oe rises exactly READ_LATENCY edges after first OE# low sample.
- Write 0x1234 to addr 5, then write 0xAB00 with ub_n=0, lb_n=1 -> read addr 5 returns 0xAB34.
- Write 0x5555 to addr 0x000400 with MEM_ADDR_BITS=10 -> read addr 0 returns 0x5555 (aliasing).
- Assert reset during WRITE data phase with 0x7777 on DQ -> no commit; prior contents of that address read back; all outputs at reset values.
- ADV# low then CE# high without data phase -> no RAM change; with PSRAM_RESPONDER_PROTOCOL_CHECK_EN protocol_error=1 and stays 1, without it stays 0.
- Back-to-back write 0xCAFE to 9 and read 9 separated by one CE#-high cycle -> read returns 0xCAFE, dq_oe never high during the write.
